// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Groups the three bus sides around the memory port arbiter:
//     if_*   : instruction-fetch requester (read only)
//     dm_*   : MEM-stage data requester (MEM_cs / MEM_we)
//     mem_*  : the single-ported memory
//   slave  : arbiter side (takes requests, drives the memory)
//   master : environment side (requesters + memory model)
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_ack_o;

    logic              dm_cs_i;
    logic              dm_we_i;
    logic [ADDR_W-1:0] dm_addr_i;
    logic [DATA_W-1:0] dm_wdata_i;
    logic [DATA_W-1:0] dm_rdata_o;
    logic              dm_ack_o;

    logic              mem_cs_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_ack_i;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_rdata_o, if_ack_o,
        input  dm_cs_i, dm_we_i, dm_addr_i, dm_wdata_i,
        output dm_rdata_o, dm_ack_o,
        output mem_cs_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i, mem_ack_i
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_rdata_o, if_ack_o,
        output dm_cs_i, dm_we_i, dm_addr_i, dm_wdata_i,
        input  dm_rdata_o, dm_ack_o,
        input  mem_cs_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i, mem_ack_i
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between instruction fetch (IF) and the
//   MEM stage (DM). Each access is granted from IDLE, the memory request is
//   registered onto mem_*_o, and the owner is acked (combinationally) when
//   mem_ack_i arrives or when the access times out. DM wins arbitration
//   unless it has already taken MAX_DM_BURST grants in a row while IF waited.
// Ports
//   clk_i, rst_n_i : clock (rising edge), async active-low reset
//   bus (slave)    : IF / DM requester sides and memory side
//   stall_o        : some request is outstanding and not acked this cycle
//   err_o          : sticky, set by any access timeout
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_DM_BURST = 4,
    parameter int TIMEOUT      = 15
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    mem_port_arbiter_if.slave   bus,
    output logic                stall_o,
    output logic                err_o
);
    localparam int BW = $clog2(MAX_DM_BURST + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_t;

    state_t        state, state_nxt;
    logic [BW-1:0] burst_cnt;
    logic [TW-1:0] tmo_cnt;

    logic grant_dm, grant_if;
    logic acc_done;   // memory acked the current access
    logic acc_tmo;    // current access abandoned after TIMEOUT busy cycles

    // Next state, grant decision and owner-side ack/rdata.
    always_comb begin
        state_nxt      = state;
        grant_dm       = 1'b0;
        grant_if       = 1'b0;
        acc_done       = 1'b0;
        acc_tmo        = 1'b0;
        bus.if_ack_o   = 1'b0;
        bus.dm_ack_o   = 1'b0;
        bus.if_rdata_o = '0;
        bus.dm_rdata_o = '0;
        case (state)
            IDLE: begin
                // IF only overrides DM once DM has used up its burst allowance.
                if (bus.dm_cs_i && (!bus.if_req_i || burst_cnt < BW'(MAX_DM_BURST))) begin
                    grant_dm  = 1'b1;
                    state_nxt = DM_BUSY;
                end else if (bus.if_req_i) begin
                    grant_if  = 1'b1;
                    state_nxt = IF_BUSY;
                end
            end
            IF_BUSY, DM_BUSY: begin
                if (bus.mem_ack_i)
                    acc_done = 1'b1;
                else if (tmo_cnt == TW'(TIMEOUT))
                    acc_tmo = 1'b1;
                if (acc_done || acc_tmo)
                    state_nxt = IDLE;
                // A timed-out access is acked with zero data.
                if (state == IF_BUSY) begin
                    bus.if_ack_o   = acc_done || acc_tmo;
                    bus.if_rdata_o = acc_done ? bus.mem_rdata_i : '0;
                end else begin
                    bus.dm_ack_o   = acc_done || acc_tmo;
                    bus.dm_rdata_o = acc_done ? bus.mem_rdata_i : '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state           <= IDLE;
            bus.mem_cs_o    <= 1'b0;
            bus.mem_we_o    <= 1'b0;
            bus.mem_addr_o  <= '0;
            bus.mem_wdata_o <= '0;
            burst_cnt       <= '0;
            tmo_cnt         <= '0;
            err_o           <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant_dm) begin
                bus.mem_cs_o    <= 1'b1;
                bus.mem_we_o    <= bus.dm_we_i;
                bus.mem_addr_o  <= bus.dm_addr_i;
                bus.mem_wdata_o <= bus.dm_wdata_i;
                // Only grants taken while IF is waiting count towards the burst.
                if (!bus.if_req_i)
                    burst_cnt <= '0;
                else if (burst_cnt != BW'(MAX_DM_BURST))
                    burst_cnt <= burst_cnt + 1'b1;
            end else if (grant_if) begin
                bus.mem_cs_o   <= 1'b1;
                bus.mem_we_o   <= 1'b0;
                bus.mem_addr_o <= bus.if_addr_i;
                burst_cnt      <= '0;
            end else if (state == IDLE) begin
                burst_cnt <= '0;
            end

            if (state != IDLE) begin
                if (acc_done || acc_tmo) begin
                    bus.mem_cs_o <= 1'b0;
                    tmo_cnt      <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end

            if (acc_tmo)
                err_o <= 1'b1;
        end
    end

    assign stall_o = (bus.if_req_i & ~bus.if_ack_o) | (bus.dm_cs_i & ~bus.dm_ack_o);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Drives the arbiter from both requester sides plus a memory model, and
//   compares every cycle against a transaction-level reference (who owns the
//   memory, what was latched, how long it has waited). Directed scenarios
//   cover single IF/DM accesses, arbitration order, burst limit, timeout and
//   reset mid-access; a long random phase follows.
module tb_mem_port_arbiter;
    localparam int MAXB = 2;
    localparam int TMO  = 15;

    logic clk = 1'b0;
    logic rst_n_i = 1'b0;
    logic stall_o, err_o;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_DM_BURST(MAXB), .TIMEOUT(TMO)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .bus(bus), .stall_o(stall_o), .err_o(err_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: owner 0 = none, 1 = IF, 2 = DM.
    int          owner, waited, dm_run;
    logic [31:0] m_addr, m_wdata;
    logic        m_we, m_err;

    // Captured per-step observations for directed checks.
    logic        s_ifack, s_dmack, s_cs;
    logic [31:0] s_ifrd, s_dmrd;
    logic [31:0] glog[$];
    logic        prev_cs;
    bit          rnd, if_keep, dm_keep;

    function automatic void model_reset();
        owner = 0; waited = 0; dm_run = 0;
        m_addr = '0; m_wdata = '0; m_we = 1'b0; m_err = 1'b0;
        prev_cs = 1'b0;
    endfunction

    // Advance the reference across one rising edge using the inputs now applied.
    function automatic void model_clock();
        if (owner != 0) begin
            if (bus.mem_ack_i || waited == TMO) begin
                if (!bus.mem_ack_i) m_err = 1'b1;
                owner = 0; waited = 0;
            end else begin
                waited++;
            end
        end else if (bus.dm_cs_i && (!bus.if_req_i || dm_run < MAXB)) begin
            owner = 2; m_addr = bus.dm_addr_i; m_we = bus.dm_we_i; m_wdata = bus.dm_wdata_i;
            dm_run = bus.if_req_i ? ((dm_run < MAXB) ? dm_run + 1 : dm_run) : 0;
        end else if (bus.if_req_i) begin
            owner = 1; m_addr = bus.if_addr_i; m_we = 1'b0; dm_run = 0;
        end else begin
            dm_run = 0;
        end
    endfunction

    task automatic step(input logic ma, input logic [31:0] mr);
        logic        fin, e_if, e_dm;
        logic [31:0] e_rd;
        model_clock();
        @(negedge clk);
        bus.mem_ack_i = ma;
        bus.mem_rdata_i = mr;
        #1;
        fin  = (owner != 0) && (ma || waited == TMO);
        e_if = fin && owner == 1;
        e_dm = fin && owner == 2;
        e_rd = ma ? mr : 32'h0;
        chk("if_ack", {31'b0, bus.if_ack_o}, {31'b0, e_if});
        chk("dm_ack", {31'b0, bus.dm_ack_o}, {31'b0, e_dm});
        if (owner != 1 || e_if) chk("if_rdata", bus.if_rdata_o, e_if ? e_rd : 32'h0);
        if (owner != 2 || (e_dm && !m_we)) chk("dm_rdata", bus.dm_rdata_o, e_dm ? e_rd : 32'h0);
        chk("mem_cs", {31'b0, bus.mem_cs_o}, {31'b0, owner != 0});
        chk("mem_we", {31'b0, bus.mem_we_o}, {31'b0, m_we});
        chk("mem_addr", bus.mem_addr_o, m_addr);
        chk("mem_wdata", bus.mem_wdata_o, m_wdata);
        chk("stall", {31'b0, stall_o},
            {31'b0, (bus.if_req_i & ~e_if) | (bus.dm_cs_i & ~e_dm)});
        chk("err", {31'b0, err_o}, {31'b0, m_err});
        s_ifack = bus.if_ack_o; s_dmack = bus.dm_ack_o;
        s_ifrd = bus.if_rdata_o; s_dmrd = bus.dm_rdata_o; s_cs = bus.mem_cs_o;
        if (bus.mem_cs_o && !prev_cs) glog.push_back(bus.mem_addr_o);
        prev_cs = bus.mem_cs_o;
        // Requester reactions within the ack cycle.
        if (rnd) begin
            if (e_if || !bus.if_req_i) begin
                bus.if_req_i  = ($urandom % 3 == 0);
                bus.if_addr_i = $urandom;
            end else if ($urandom % 40 == 0) bus.if_req_i = 1'b0;
            if (e_dm || !bus.dm_cs_i) begin
                bus.dm_cs_i    = ($urandom % 2 == 0);
                bus.dm_we_i    = $urandom % 2;
                bus.dm_addr_i  = $urandom;
                bus.dm_wdata_i = $urandom;
            end else if ($urandom % 40 == 0) bus.dm_cs_i = 1'b0;
        end else begin
            if (e_if && !if_keep) bus.if_req_i = 1'b0;
            if (e_dm && !dm_keep) bus.dm_cs_i = 1'b0;
        end
    endtask

    initial begin
        int k0, kack, quiet;
        bus.if_req_i = 0; bus.if_addr_i = 0; bus.dm_cs_i = 0; bus.dm_we_i = 0;
        bus.dm_addr_i = 0; bus.dm_wdata_i = 0; bus.mem_rdata_i = 0; bus.mem_ack_i = 0;
        rnd = 0; if_keep = 0; dm_keep = 0;
        model_reset();

        // Reset state
        #12;
        chk("rst_cs", {31'b0, bus.mem_cs_o}, 32'h0);
        chk("rst_we", {31'b0, bus.mem_we_o}, 32'h0);
        chk("rst_addr", bus.mem_addr_o, 32'h0);
        chk("rst_wdata", bus.mem_wdata_o, 32'h0);
        chk("rst_err", {31'b0, err_o}, 32'h0);
        @(negedge clk);
        rst_n_i = 1'b1;

        // Single IF fetch, memory answers two cycles after mem_cs_o
        bus.if_req_i = 1; bus.if_addr_i = 32'h40;
        step(0, 0);
        chk("t1_addr", bus.mem_addr_o, 32'h40);
        chk("t1_we", {31'b0, bus.mem_we_o}, 32'h0);
        chk("t1_stall", {31'b0, stall_o}, 32'h1);
        step(0, 0);
        step(1, 32'hCAFE0001);
        chk("t1_ack", {31'b0, s_ifack}, 32'h1);
        chk("t1_rdata", s_ifrd, 32'hCAFE0001);
        step(0, 0);
        chk("t1_pulse", {31'b0, s_ifack}, 32'h0);
        chk("t1_stall_end", {31'b0, stall_o}, 32'h0);

        // Single DM write
        bus.dm_cs_i = 1; bus.dm_we_i = 1; bus.dm_addr_i = 32'h10; bus.dm_wdata_i = 32'hDEADBEEF;
        step(0, 0);
        chk("t2_we", {31'b0, bus.mem_we_o}, 32'h1);
        chk("t2_wdata", bus.mem_wdata_o, 32'hDEADBEEF);
        step(1, 32'h5555AAAA);
        chk("t2_dm_ack", {31'b0, s_dmack}, 32'h1);
        chk("t2_if_ack", {31'b0, s_ifack}, 32'h0);
        step(0, 0);

        // Simultaneous requests: DM first, IF at the next IDLE
        glog.delete();
        bus.if_req_i = 1; bus.if_addr_i = 32'h100;
        bus.dm_cs_i = 1; bus.dm_we_i = 0; bus.dm_addr_i = 32'h200;
        repeat (4) step(1, $urandom);
        chk("t3_n", glog.size(), 2);
        if (glog.size() >= 2) begin
            chk("t3_first", glog[0], 32'h200);
            chk("t3_second", glog[1], 32'h100);
        end
        step(0, 0);

        // Burst limit 2: DM, DM, IF, DM
        glog.delete();
        dm_keep = 1;
        bus.if_req_i = 1; bus.if_addr_i = 32'h100;
        bus.dm_cs_i = 1; bus.dm_addr_i = 32'h200;
        repeat (8) step(1, $urandom);
        bus.dm_cs_i = 0; dm_keep = 0;
        step(0, 0); step(0, 0);
        chk("t4_n", glog.size(), 4);
        if (glog.size() >= 4) begin
            chk("t4_g0", glog[0], 32'h200);
            chk("t4_g1", glog[1], 32'h200);
            chk("t4_g2", glog[2], 32'h100);
            chk("t4_g3", glog[3], 32'h200);
        end

        // Timeout: memory never answers
        bus.if_req_i = 1; bus.if_addr_i = 32'h300;
        k0 = -1; kack = -1;
        for (int k = 0; k < 40; k++) begin
            step(0, 32'hFFFFFFFF);
            if (s_cs && k0 < 0) k0 = k;
            if (s_ifack) begin kack = k; break; end
        end
        chk("t5_seen", {31'b0, kack >= 0}, 32'h1);
        chk("t5_lat", kack - k0, TMO);
        chk("t5_rdata", s_ifrd, 32'h0);
        step(0, 0);
        chk("t5_err", {31'b0, err_o}, 32'h1);
        chk("t5_idle", {31'b0, bus.mem_cs_o}, 32'h0);

        // Random traffic, with occasional silent-memory stretches
        rnd = 1; quiet = 0;
        for (int n = 0; n < 3000; n++) begin
            if (quiet > 0) quiet--;
            else if ($urandom % 150 == 0) quiet = 20;
            step((quiet == 0) && ($urandom % 100 < 40), $urandom);
        end
        rnd = 0;
        bus.if_req_i = 0; bus.dm_cs_i = 0;
        for (int k = 0; k < 40 && owner != 0; k++) step(1, 0);
        step(0, 0);

        // Reset in the middle of a DM read
        bus.dm_cs_i = 1; bus.dm_we_i = 0; bus.dm_addr_i = 32'h500;
        step(0, 0);
        chk("t6_busy", {31'b0, bus.mem_cs_o}, 32'h1);
        bus.mem_ack_i = 1; rst_n_i = 1'b0;
        #1;
        chk("t6_cs", {31'b0, bus.mem_cs_o}, 32'h0);
        chk("t6_noack", {31'b0, bus.dm_ack_o}, 32'h0);
        chk("t6_err", {31'b0, err_o}, 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        chk("t6_noack2", {31'b0, bus.dm_ack_o}, 32'h0);
        rst_n_i = 1'b1;
        bus.dm_addr_i = 32'h600;
        step(0, 0);
        chk("t6_addr", bus.mem_addr_o, 32'h600);
        step(1, 32'h12345678);
        chk("t6_ack", {31'b0, s_dmack}, 32'h1);
        chk("t6_rdata", s_dmrd, 32'h12345678);
        step(0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
